// File: rtl/tap_pkg.sv
// Shared definitions for the JTAG TAP: state encoding, reset opcode, IR capture pattern.
package tap_pkg;

    typedef enum logic [3:0] {
        TAP_TLR    = 4'd0,
        TAP_RTI    = 4'd1,
        TAP_SEL_DR = 4'd2,
        TAP_CAP_DR = 4'd3,
        TAP_SH_DR  = 4'd4,
        TAP_EX1_DR = 4'd5,
        TAP_PAU_DR = 4'd6,
        TAP_EX2_DR = 4'd7,
        TAP_UPD_DR = 4'd8,
        TAP_SEL_IR = 4'd9,
        TAP_CAP_IR = 4'd10,
        TAP_SH_IR  = 4'd11,
        TAP_EX1_IR = 4'd12,
        TAP_PAU_IR = 4'd13,
        TAP_EX2_IR = 4'd14,
        TAP_UPD_IR = 4'd15
    } tap_state_t;

    // Opcode forced into the active IR in Test-Logic-Reset.
    localparam int unsigned OPC_IDCODE = 32'd1;

    // Low bits loaded into the IR shift register in Capture-IR; upper bits are zero.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller: state register plus one-hot phase strobes.
module jtag_tap_fsm
    import tap_pkg::*;
(
    input  logic       tck_i,
    input  logic       trst_ni,
    input  logic       tms_i,
    output tap_state_t state_o,
    output logic       tlr_o,
    output logic       capture_dr_o,
    output logic       shift_dr_o,
    output logic       update_dr_o,
    output logic       capture_ir_o,
    output logic       shift_ir_o,
    output logic       update_ir_o
);

    tap_state_t state_q;

    // State register and transition table, advanced on every rising TCK edge.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= TAP_TLR;
        end else begin
            case (state_q)
                TAP_TLR:    state_q <= tms_i ? TAP_TLR    : TAP_RTI;
                TAP_RTI:    state_q <= tms_i ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_DR: state_q <= tms_i ? TAP_SEL_IR : TAP_CAP_DR;
                TAP_CAP_DR: state_q <= tms_i ? TAP_EX1_DR : TAP_SH_DR;
                TAP_SH_DR:  state_q <= tms_i ? TAP_EX1_DR : TAP_SH_DR;
                TAP_EX1_DR: state_q <= tms_i ? TAP_UPD_DR : TAP_PAU_DR;
                TAP_PAU_DR: state_q <= tms_i ? TAP_EX2_DR : TAP_PAU_DR;
                TAP_EX2_DR: state_q <= tms_i ? TAP_UPD_DR : TAP_SH_DR;
                TAP_UPD_DR: state_q <= tms_i ? TAP_SEL_DR : TAP_RTI;
                TAP_SEL_IR: state_q <= tms_i ? TAP_TLR    : TAP_CAP_IR;
                TAP_CAP_IR: state_q <= tms_i ? TAP_EX1_IR : TAP_SH_IR;
                TAP_SH_IR:  state_q <= tms_i ? TAP_EX1_IR : TAP_SH_IR;
                TAP_EX1_IR: state_q <= tms_i ? TAP_UPD_IR : TAP_PAU_IR;
                TAP_PAU_IR: state_q <= tms_i ? TAP_EX2_IR : TAP_PAU_IR;
                TAP_EX2_IR: state_q <= tms_i ? TAP_UPD_IR : TAP_SH_IR;
                TAP_UPD_IR: state_q <= tms_i ? TAP_SEL_DR : TAP_RTI;
                default:    state_q <= TAP_TLR;
            endcase
        end
    end

    // Strobes are pure decodes of the registered state, so they are glitch-free per TCK.
    assign state_o      = state_q;
    assign tlr_o        = (state_q == TAP_TLR);
    assign capture_dr_o = (state_q == TAP_CAP_DR);
    assign shift_dr_o   = (state_q == TAP_SH_DR);
    assign update_dr_o  = (state_q == TAP_UPD_DR);
    assign capture_ir_o = (state_q == TAP_CAP_IR);
    assign shift_ir_o   = (state_q == TAP_SH_IR);
    assign update_ir_o  = (state_q == TAP_UPD_IR);

endmodule

// File: rtl/jtag_tap.sv
// JTAG Test Access Port: IR, IDCODE/BYPASS/user data registers and negedge TDO stage.
module jtag_tap
    import tap_pkg::*;
#(
    parameter int unsigned                IR_WIDTH         = 5,
    parameter logic [31:0]                IDCODE_VALUE     = 32'h1000_0001,
    parameter int unsigned                NUM_USER_DR      = 2,
    parameter int unsigned                USER_DR_WIDTH    = 41,
    parameter logic [IR_WIDTH-1:0]        USER_OPCODE_BASE = 5'h10
) (
    input  logic                                  tck_i,
    input  logic                                  trst_ni,
    input  logic                                  tms_i,
    input  logic                                  tdi_i,
    output logic                                  tdo_o,
    output logic                                  tdo_oe_o,
    input  logic [NUM_USER_DR*USER_DR_WIDTH-1:0]  user_capture_data_i,
    output logic [NUM_USER_DR-1:0]                user_capture_o,
    output logic [NUM_USER_DR-1:0]                user_update_o,
    output logic [USER_DR_WIDTH-1:0]              user_update_data_o,
    output logic [3:0]                            tap_state_o,
    output logic                                  test_logic_reset_o
);

    tap_state_t                 state_s;
    logic                       tlr_s;
    logic                       capture_dr_s;
    logic                       shift_dr_s;
    logic                       update_dr_s;
    logic                       capture_ir_s;
    logic                       shift_ir_s;
    logic                       update_ir_s;

    logic [IR_WIDTH-1:0]        ir_shift_q;
    logic [IR_WIDTH-1:0]        ir_q;
    logic [31:0]                idcode_q;
    logic                       bypass_q;
    logic [USER_DR_WIDTH-1:0]   user_shift_q;
    logic                       tdo_q;
    logic                       tdo_oe_q;

    logic                       sel_idcode_s;
    logic [NUM_USER_DR-1:0]     sel_user_s;
    logic [USER_DR_WIDTH-1:0]   user_cap_data_s;
    logic                       ir_branch_s;
    logic                       tdo_s;

    jtag_tap_fsm u_fsm (
        .tck_i        (tck_i),
        .trst_ni      (trst_ni),
        .tms_i        (tms_i),
        .state_o      (state_s),
        .tlr_o        (tlr_s),
        .capture_dr_o (capture_dr_s),
        .shift_dr_o   (shift_dr_s),
        .update_dr_o  (update_dr_s),
        .capture_ir_o (capture_ir_s),
        .shift_ir_o   (shift_ir_s),
        .update_ir_o  (update_ir_s)
    );

    // Instruction decode: IDCODE, then user channels; all-ones and unknown opcodes fall to BYPASS.
    always_comb begin
        sel_idcode_s = 1'b0;
        sel_user_s   = '0;
        if (ir_q == IR_WIDTH'(OPC_IDCODE)) begin
            sel_idcode_s = 1'b1;
        end else if (&ir_q) begin
            sel_user_s = '0;
        end else begin
            for (int k = 0; k < int'(NUM_USER_DR); k++) begin
                if (ir_q == (USER_OPCODE_BASE + IR_WIDTH'(k))) begin
                    sel_user_s[k] = 1'b1;
                end else begin
                    sel_user_s[k] = 1'b0;
                end
            end
        end
    end

    // Select the capture slice of the active user channel (one-hot select, OR-combined).
    always_comb begin
        user_cap_data_s = '0;
        for (int k = 0; k < int'(NUM_USER_DR); k++) begin
            if (sel_user_s[k]) begin
                user_cap_data_s = user_cap_data_s |
                                  user_capture_data_i[k*USER_DR_WIDTH +: USER_DR_WIDTH];
            end else begin
                user_cap_data_s = user_cap_data_s;
            end
        end
    end

    // Instruction register: capture/shift chain plus the active IR, reloaded only at UPD_IR or TLR.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            ir_shift_q <= '0;
            ir_q       <= IR_WIDTH'(OPC_IDCODE);
        end else begin
            if (capture_ir_s) begin
                ir_shift_q <= IR_WIDTH'(IR_CAPTURE);
            end else if (shift_ir_s) begin
                ir_shift_q <= {tdi_i, ir_shift_q[IR_WIDTH-1:1]};
            end
            if (tlr_s) begin
                ir_q <= IR_WIDTH'(OPC_IDCODE);
            end else if (update_ir_s) begin
                ir_q <= ir_shift_q;
            end
        end
    end

    // Data registers: only the register selected by the active IR captures or shifts.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            idcode_q     <= 32'h0000_0000;
            bypass_q     <= 1'b0;
            user_shift_q <= '0;
        end else if (capture_dr_s) begin
            if (sel_idcode_s) begin
                idcode_q <= IDCODE_VALUE;
            end else if (|sel_user_s) begin
                user_shift_q <= user_cap_data_s;
            end else begin
                bypass_q <= 1'b0;
            end
        end else if (shift_dr_s) begin
            if (sel_idcode_s) begin
                idcode_q <= {tdi_i, idcode_q[31:1]};
            end else if (|sel_user_s) begin
                user_shift_q <= {tdi_i, user_shift_q[USER_DR_WIDTH-1:1]};
            end else begin
                bypass_q <= tdi_i;
            end
        end
    end

    assign ir_branch_s = (state_s >= TAP_SEL_IR);

    // Serial output source: IR chain in the IR branch, otherwise the selected data register.
    always_comb begin
        tdo_s = 1'b0;
        if (ir_branch_s) begin
            tdo_s = ir_shift_q[0];
        end else if (sel_idcode_s) begin
            tdo_s = idcode_q[0];
        end else if (|sel_user_s) begin
            tdo_s = user_shift_q[0];
        end else begin
            tdo_s = bypass_q;
        end
    end

    // Launch TDO and its enable on the falling edge so the probe samples a stable bit on the rise.
    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            tdo_q    <= 1'b0;
            tdo_oe_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_s;
            tdo_oe_q <= shift_dr_s | shift_ir_s;
        end
    end

    assign tdo_o              = tdo_q;
    assign tdo_oe_o           = tdo_oe_q;
    assign user_capture_o     = capture_dr_s ? sel_user_s : '0;
    assign user_update_o      = update_dr_s  ? sel_user_s : '0;
    assign user_update_data_o = user_shift_q;
    assign tap_state_o        = state_s;
    assign test_logic_reset_o = tlr_s;

endmodule

// File: tb/tb_jtag_tap.sv
// Directed self-checking bench for jtag_tap.
module tb_jtag_tap;

    logic        tck_i;
    logic        trst_ni;
    logic        tms_i;
    logic        tdi_i;
    logic        tdo_o;
    logic        tdo_oe_o;
    logic [81:0] user_capture_data_i;
    logic [1:0]  user_capture_o;
    logic [1:0]  user_update_o;
    logic [40:0] user_update_data_o;
    logic [3:0]  tap_state_o;
    logic        test_logic_reset_o;

    int checks_q;
    int errors_q;
    int cap_cnt;
    int upd_cnt;

    jtag_tap dut (
        .tck_i               (tck_i),
        .trst_ni             (trst_ni),
        .tms_i               (tms_i),
        .tdi_i               (tdi_i),
        .tdo_o               (tdo_o),
        .tdo_oe_o            (tdo_oe_o),
        .user_capture_data_i (user_capture_data_i),
        .user_capture_o      (user_capture_o),
        .user_update_o       (user_update_o),
        .user_update_data_o  (user_update_data_o),
        .tap_state_o         (tap_state_o),
        .test_logic_reset_o  (test_logic_reset_o)
    );

    initial tck_i = 1'b0;
    always #5 tck_i = ~tck_i;

    // Count rising edges during which any user capture/update strobe is high.
    always @(posedge tck_i) begin
        if (|user_capture_o) cap_cnt <= cap_cnt + 1;
        if (|user_update_o)  upd_cnt <= upd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_q++;
        if (obs !== exp) begin
            errors_q++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One TCK: drive inputs in the low phase, return just after the following falling edge.
    task automatic step(input logic tms, input logic tdi);
        tms_i = tms;
        tdi_i = tdi;
        @(posedge tck_i);
        @(negedge tck_i);
        #1;
    endtask

    // IR scan from RTI back to RTI; dout collects tdo bits LSB first.
    task automatic scan_ir(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo_o;
            step(i == n - 1, din[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // DR scan from RTI back to RTI, also recording capture/update strobes and update data.
    task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output logic [1:0] cap, output logic [1:0] upd,
                           output logic [40:0] upd_data);
        dout = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        cap = user_capture_o;
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo_o;
            step(i == n - 1, din[i]);
        end
        step(1'b1, 1'b0);
        upd      = user_update_o;
        upd_data = user_update_data_o;
        step(1'b0, 1'b0);
    endtask

    logic [63:0] dout;
    logic [1:0]  cap;
    logic [1:0]  upd;
    logic [40:0] upd_data;
    int          c0;
    int          u0;

    initial begin
        checks_q = 0;
        errors_q = 0;
        cap_cnt  = 0;
        upd_cnt  = 0;
        trst_ni  = 1'b0;
        tms_i    = 1'b1;
        tdi_i    = 1'b0;
        user_capture_data_i = {41'h1_2345_6789A, 41'h0_5555_AAAA5};

        #12;
        chk("rst_state", 64'(tap_state_o), 64'd0);
        chk("rst_tlr", 64'(test_logic_reset_o), 64'd1);
        chk("rst_tdo", 64'(tdo_o), 64'd0);
        chk("rst_oe", 64'(tdo_oe_o), 64'd0);
        chk("rst_cap", 64'(user_capture_o), 64'd0);
        chk("rst_upd", 64'(user_update_o), 64'd0);
        @(negedge tck_i);
        #1;
        trst_ni = 1'b1;

        // IDCODE read straight after reset.
        step(1'b0, 1'b0);
        scan_dr(32, 64'd0, dout, cap, upd, upd_data);
        chk("idcode", dout, 64'h1000_0001);
        chk("idcode_state_rti", 64'(tap_state_o), 64'd1);
        chk("idcode_oe_off", 64'(tdo_oe_o), 64'd0);

        // Partial IDCODE shift, long pause, resume: bit 28 must still come out next.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("sh_dr_oe", 64'(tdo_oe_o), 64'd1);
        for (int i = 0; i < 28; i++) step(i == 27, 1'b0);
        step(1'b0, 1'b0);
        chk("pau_state", 64'(tap_state_o), 64'd6);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("pause_hold_bit28", 64'(tdo_o), 64'd1);

        // Five TMS=1 clocks from SH_DR reach TLR.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("tms5_tlr", 64'(tap_state_o), 64'd0);
        chk("tms5_tlr_flag", 64'(test_logic_reset_o), 64'd1);
        step(1'b0, 1'b0);

        // IR capture pattern while loading BYPASS (all ones).
        scan_ir(5, 64'h1F, dout);
        chk("ir_capture", dout, 64'h01);

        // BYPASS with 1,0,1,1 then pad 0: out 0,1,0,1,1.
        scan_dr(5, 64'h0D, dout, cap, upd, upd_data);
        chk("bypass_1f", dout, 64'h1A);

        // Unassigned opcode 7 behaves as BYPASS.
        scan_ir(5, 64'h07, dout);
        chk("ir_capture_2", dout, 64'h01);
        scan_dr(5, 64'h0D, dout, cap, upd, upd_data);
        chk("bypass_07", dout, 64'h1A);

        // User channel 1.
        scan_ir(5, 64'h11, dout);
        c0 = cap_cnt;
        u0 = upd_cnt;
        scan_dr(41, 64'h0_ABCD_EF012, dout, cap, upd, upd_data);
        chk("user1_out", dout, 64'h1_2345_6789A);
        chk("user1_cap", 64'(cap), 64'h2);
        chk("user1_upd", 64'(upd), 64'h2);
        chk("user1_upd_data", 64'(upd_data), 64'h0_ABCD_EF012);
        chk("user1_cap_len", 64'(cap_cnt - c0), 64'd1);
        chk("user1_upd_len", 64'(upd_cnt - u0), 64'd1);

        // User channel 0 takes its own slice.
        scan_ir(5, 64'h10, dout);
        scan_dr(41, 64'h1_0F0F_0F0F0, dout, cap, upd, upd_data);
        chk("user0_out", dout, 64'h0_5555_AAAA5);
        chk("user0_cap", 64'(cap), 64'h1);
        chk("user0_upd", 64'(upd), 64'h1);
        chk("user0_upd_data", 64'(upd_data), 64'h1_0F0F_0F0F0);

        // Reset during the 20th bit of a user-channel shift.
        scan_ir(5, 64'h11, dout);
        u0 = upd_cnt;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 19; i++) step(1'b0, 1'b1);
        chk("mid_oe_before", 64'(tdo_oe_o), 64'd1);
        trst_ni = 1'b0;
        #1;
        chk("mid_rst_state", 64'(tap_state_o), 64'd0);
        chk("mid_rst_oe", 64'(tdo_oe_o), 64'd0);
        chk("mid_rst_tdo", 64'(tdo_o), 64'd0);
        chk("mid_rst_upd", 64'(user_update_o), 64'd0);
        #1;
        trst_ni = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("mid_rst_no_upd", 64'(upd_cnt - u0), 64'd0);
        scan_dr(32, 64'd0, dout, cap, upd, upd_data);
        chk("mid_rst_ir_idcode", dout, 64'h1000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
        $finish;
    end

endmodule

// File: doc/jtag_tap.md
# jtag_tap

Parametrised IEEE 1149.1 Test Access Port: complete 16-state TAP FSM, IR of configurable length, built-in IDCODE and BYPASS data registers, and `NUM_USER_DR` user data-register channels with capture/update handshakes toward the debug transport logic. It sits between the chip-level JTAG pins and the debug module. It drives `tdo_o` and its output enable directly, so no external shift logic is needed.

## Interface
- `IR_WIDTH`, 5: instruction register length; must be ≥ 2.
- `IDCODE_VALUE`, 32'h1000_0001: value captured by IDCODE; bit 0 must be 1.
- `NUM_USER_DR`, 2: number of user DR channels, 1..8.
- `USER_DR_WIDTH`, 41: length of every user DR; must be ≥ 2.
- `USER_OPCODE_BASE`, 5'h10: opcode of user channel 0; channel k uses `USER_OPCODE_BASE+k`.

Ports:
- `tck_i`  in  1  JTAG clock; the only clock.
- `trst_ni`  in  1  asynchronous, active-low reset.
- `tms_i`  in  1  mode select, sampled on posedge `tck_i`.
- `tdi_i`  in  1  serial data in, sampled on posedge `tck_i`.
- `tdo_o`  out  1  serial data out, launched on negedge `tck_i`.
- `tdo_oe_o`  out  1  TDO enable, launched on negedge `tck_i`.
- `user_capture_data_i`  in  `NUM_USER_DR*USER_DR_WIDTH`  parallel capture data; channel k occupies slice k.
- `user_capture_o`  out  `NUM_USER_DR`  bit k high while in CAPTURE_DR with channel k selected.
- `user_update_o`  out  `NUM_USER_DR`  bit k high while in UPDATE_DR with channel k selected.
- `user_update_data_o`  out  `USER_DR_WIDTH`  user shift-register contents; valid while any `user_update_o` bit is high.
- `tap_state_o`  out  4  current FSM state (`tap_pkg::tap_state_t` encoding).
- `test_logic_reset_o`  out  1  high in TEST_LOGIC_RESET.

## Operation
- FSM states, each written as state: next state when tms=0 / next state when tms=1.
  - TLR: RTI / TLR.
  - RTI: RTI / SEL_DR.
  - SEL_DR: CAP_DR / SEL_IR.
  - CAP_DR: SH_DR / EX1_DR.
  - SH_DR: SH_DR / EX1_DR.
  - EX1_DR: PAU_DR / UPD_DR.
  - PAU_DR: PAU_DR / EX2_DR.
  - EX2_DR: SH_DR / UPD_DR.
  - UPD_DR: RTI / SEL_DR.
  - The IR branch mirrors the DR branch, except SEL_IR goes to TLR on tms=1.
- Any state reaches TLR after at most 5 consecutive tms=1 clocks.
- IR shift register:
  - CAP_IR loads {0…0, 2'b01}.
  - SH_IR shifts right, with `tdi_i` entering the MSB.
  - UPD_IR copies the shift register into the active IR.
  - TLR forces the active IR to `OPC_IDCODE` (1).
- Instruction decode:
  - 1 selects IDCODE.
  - All-ones selects BYPASS.
  - `USER_OPCODE_BASE+k` with k < `NUM_USER_DR` selects user channel k.
  - Every other opcode, including 0, selects BYPASS.
- DR capture in CAP_DR:
  - IDCODE loads `IDCODE_VALUE`.
  - BYPASS loads 0.
  - User channel k loads slice k of `user_capture_data_i`.
- DR shift in SH_DR: the selected register shifts right, with `tdi_i` entering its MSB. BYPASS is a single bit.
- User channels share one `USER_DR_WIDTH` shift register.
- `tdo_o` is the LSB of the selected shift register (IR in the IR branch).
- `tdo_oe_o` is 1 only for SH_DR and SH_IR.
- Reset values:
  - state TLR.
  - active IR `OPC_IDCODE`.
  - all shift registers 0.
  - `tdo_o`=0, `tdo_oe_o`=0.
  - `user_capture_o`=0, `user_update_o`=0.
  - `tap_state_o`=0, `test_logic_reset_o`=1.

## Timing
- State, shift registers and IR update on posedge `tck_i`.
- `tdo_o` and `tdo_oe_o` update on the negedge `tck_i` that follows entry into the relevant state.
- The first DR bit appears on `tdo_o` half a cycle after entering SH_DR.
- n bits are shifted by n posedges spent in SH_xR, counting the posedge that leaves it.
- BYPASS delays `tdi_i` to `tdo_o` by exactly 1 tck.
- `user_capture_o` and `user_update_o`:
  - combinational from the state and the active IR.
  - each lasts exactly one tck per pass.
- Capture data is sampled at the posedge that leaves CAP_DR.
- The active IR changes only at the posedge leaving UPD_IR or in TLR. It never changes mid-DR-scan.
- `trst_ni` low at any time:
  - immediately forces the reset values above, even mid-shift.
  - no update pulse is generated.
  - a shift in progress is discarded.
- Pausing (PAU_xR) holds shift-register contents indefinitely.

## Structure
- `tap_pkg` holds:
  - the `tap_state_t` enum, in the order TLR=0, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR=15.
  - `OPC_IDCODE`.
  - the IR capture pattern.
- Sub-module `jtag_tap_fsm`:
  - the state register and next-state logic only.
  - outputs the state plus one-hot capture/shift/update strobes.
- `jtag_tap` holds the IR, the DR muxing and the negedge TDO stage.

## Test plan
- From an arbitrary state, 5×tms=1 → `tap_state_o`=0 and active IR=1.
- Read IDCODE after reset:
  - stimulus: tms 0,1,0,0, then 32 shifts with tms=1 on the last.
  - required: sampled `tdo_o` bits, LSB first, equal 32'h1000_0001.
- IR capture:
  - stimulus: shift IR while driving `tdi_i`=1.
  - required: first two `tdo_o` bits are 1,0; remaining bits are 0.
- BYPASS:
  - stimulus: load IR 5'h1F, then shift pattern 1011 through DR.
  - required: `tdo_o` shows 0 then 1,0,1,1 (one-tck delay).
  - Repeat with opcode 5'h07 and expect identical behaviour.
- User channel 1 (opcode 5'h11):
  - stimulus: `user_capture_data_i` slice 1 = 41'h1_2345_6789A; shift in 41'h0_ABCD_EF012.
  - required: 41'h1_2345_6789A shifted out; `user_capture_o`=2'b10 for 1 cycle; in UPD_DR, `user_update_o`=2'b10 and `user_update_data_o`=41'h0_ABCD_EF012.
- Reset mid-shift:
  - stimulus: pulse `trst_ni` low during the 20th bit of a user DR shift.
  - required: immediate TLR, `tdo_oe_o`=0, no `user_update_o` pulse, active IR=1.
